// File: rtl/echo_buf_if.sv
// Echo buffer controller signal bundle.
// The environment drives master; the controller takes slave.
interface echo_buf_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              mode_i;
  logic              eor_i;
  logic [DATA_W-1:0] rx_data_i;
  logic              eot_i;
  logic              sttx_o;
  logic [DATA_W-1:0] tx_data_o;
  logic [CW-1:0]     count_o;
  logic              busy_o;
  logic              overflow_o;
  logic              timeout_o;

  modport master (
    output mode_i,
    output eor_i,
    output rx_data_i,
    output eot_i,
    input  sttx_o,
    input  tx_data_o,
    input  count_o,
    input  busy_o,
    input  overflow_o,
    input  timeout_o
  );

  modport slave (
    input  mode_i,
    input  eor_i,
    input  rx_data_i,
    input  eot_i,
    output sttx_o,
    output tx_data_o,
    output count_o,
    output busy_o,
    output overflow_o,
    output timeout_o
  );
endinterface

// File: rtl/echo_buf_ctrl.sv
// Receive-to-transmit echo buffer: FIFO plus transmit start FSM.
// Byte mode echoes each word; line mode holds words until a flush.
module echo_buf_ctrl #(
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 16,
  parameter logic [DATA_W-1:0] TERM   = DATA_W'(8'h0D),
  parameter int                TO_CYC = 1024
) (
  input logic       clk_i,
  input logic       rst_i,
  echo_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [TW-1:0]     to_cnt_q;
  logic [TW-1:0]     to_cnt_d;
  logic [DATA_W-1:0] tx_q;
  logic              eor_q;
  logic              flush_q;
  logic              flush_d;
  logic              mode_q;
  logic              mode_eff;
  logic              sttx_q;
  logic              tmo_q;
  logic              tmo_d;
  logic              ovf_q;
  logic              rx_ev;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;
  logic              load;

  // Mode is only re-read while idle with nothing pending a flush.
  always_comb begin
    rx_ev    = bus.eor_i & ~eor_q;
    pop      = (state_q == START);
    full     = (count_q == CW'(DEPTH));
    push     = rx_ev & (~full | pop);
    drop     = rx_ev & full & ~pop;
    count_d  = count_q + CW'(push) - CW'(pop);
    mode_eff = (state_q == IDLE && !flush_q) ? bus.mode_i : mode_q;
  end

  always_comb begin
    flush_d = flush_q;
    if (push && (bus.rx_data_i == TERM || count_d == CW'(DEPTH)))
      flush_d = 1'b1;
    else if (pop && count_q == CW'(1) && !push)
      flush_d = 1'b0;
    if (!mode_eff)
      flush_d = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    to_cnt_d = '0;
    tmo_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0 && (!mode_eff || flush_q))
          state_d = START;
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.eot_i) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == TW'(TO_CYC - 1)) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.eot_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Start pulse and data are registered so both appear in START.
  assign load = (state_q == IDLE) && (state_d == START);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      to_cnt_q <= '0;
      tx_q     <= '0;
      eor_q    <= 1'b1;
      flush_q  <= 1'b0;
      mode_q   <= 1'b0;
      sttx_q   <= 1'b0;
      tmo_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      to_cnt_q <= to_cnt_d;
      eor_q    <= bus.eor_i;
      flush_q  <= flush_d;
      mode_q   <= mode_eff;
      sttx_q   <= load;
      tmo_q    <= tmo_d;
      if (push)
        wptr_q <= wptr_q + AW'(1);
      if (pop)
        rptr_q <= rptr_q + AW'(1);
      if (drop)
        ovf_q <= 1'b1;
      if (load)
        tx_q <= mem[rptr_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && push)
      mem[wptr_q] <= bus.rx_data_i;
  end

  assign bus.sttx_o     = sttx_q;
  assign bus.tx_data_o  = tx_q;
  assign bus.count_o    = count_q;
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.overflow_o = ovf_q;
  assign bus.timeout_o  = tmo_q;
endmodule

// File: tb/tb_echo_buf_ctrl.sv
// Bench for echo_buf_ctrl: random and directed receive traffic,
// queue-based reference model, scoreboard on every start pulse.
module tb_echo_buf_ctrl;
  localparam int         DW  = 8;
  localparam int         DEP = 16;
  localparam int         TOC = 32;
  localparam logic [7:0] TRM = 8'h0D;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  echo_buf_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();

  echo_buf_ctrl #(
    .DATA_W(DW),
    .DEPTH (DEP),
    .TERM  (TRM),
    .TO_CYC(TOC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         m_cnt = 0;
  bit         m_ovf = 0;
  bit         m_flush = 0;
  bit         m_eor = 1;
  bit         chk_en = 0;
  int         n_sttx = 0;
  int         tx_mode = 0;
  int         tx_lat = 0;
  bit         ev;
  bit         acc;
  bit         pp;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Reference model: FIFO as a queue, occupancy and flush by rule.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", bus.count_o, m_cnt);
      check("overflow", bus.overflow_o, m_ovf);
    end
    if (!rst) begin
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 0;
      m_flush = 0;
      m_eor = 1;
    end else begin
      ev = bus.eor_i && !m_eor;
      m_eor = bus.eor_i;
      pp = bus.sttx_o;
      if (pp) begin
        n_sttx++;
        check("line_gate", !bus.mode_i || m_flush, 1);
        if (exp_q.size() == 0)
          check("sttx_empty", 1, 0);
        else
          check("tx_data", bus.tx_data_o, exp_q.pop_front());
      end
      acc = ev && (m_cnt < DEP || pp);
      if (ev && !acc)
        m_ovf = 1;
      if (acc)
        exp_q.push_back(bus.rx_data_i);
      m_cnt = m_cnt + int'(acc) - int'(pp);
      if (bus.mode_i && acc && (bus.rx_data_i == TRM || m_cnt == DEP))
        m_flush = 1;
      else if (pp && m_cnt == 0 && !acc)
        m_flush = 0;
      if (!bus.mode_i)
        m_flush = 0;
    end
  end

  // Transmitter model: 0 idle high, 1 answers starts, 2 stuck low.
  initial begin
    int l;
    bus.eot_i = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mode == 2) begin
        @(posedge clk);
        #1 bus.eot_i = 1'b0;
      end else if (tx_mode == 1 && bus.sttx_o) begin
        l = (tx_lat > 0) ? tx_lat : int'($urandom_range(1, 6));
        repeat (l) @(posedge clk);
        #1 bus.eot_i = 1'b0;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 bus.eot_i = 1'b1;
      end else begin
        @(posedge clk);
        #1 bus.eot_i = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic rx(input logic [7:0] w);
    @(posedge clk);
    #1 bus.eor_i = 1'b0;
    bus.rx_data_i = 8'($urandom);
    @(posedge clk);
    #1 bus.eor_i = 1'b1;
    bus.rx_data_i = w;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.eor_i = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    repeat (2) @(negedge clk);
    while (!(bus.count_o == '0 && !bus.busy_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_drain"}, n < 3000, 1);
  endtask

  task automatic wait_sttx(input string nm, input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.sttx_o !== 1'b1 && n < lim);
    check({nm, "_sttx"}, n < lim, 1);
  endtask

  initial begin
    int n0;
    int k;
    logic [7:0] w;
    bus.mode_i    = 1'b0;
    bus.eor_i     = 1'b1;
    bus.rx_data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sttx", bus.sttx_o, 0);
    check("rst_txdata", bus.tx_data_o, 0);
    check("rst_count", bus.count_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_ovf", bus.overflow_o, 0);
    check("rst_tmo", bus.timeout_o, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1;

    // Single byte echo with a 10-cycle transmitter delay.
    tx_mode = 1;
    tx_lat  = 10;
    n0 = n_sttx;
    rx(8'h41);
    wait_drain("byte41");
    check("byte41_starts", n_sttx - n0, 1);
    check("byte41_busy", bus.busy_o, 0);
    tx_lat = 0;

    // Line mode: nothing leaves before the terminator.
    do_reset();
    bus.mode_i = 1'b1;
    n0 = n_sttx;
    rx(8'h61);
    rx(8'h62);
    idle(8);
    @(negedge clk);
    check("line_hold_starts", n_sttx - n0, 0);
    check("line_hold_count", bus.count_o, 2);
    rx(TRM);
    wait_drain("line");
    check("line_starts", n_sttx - n0, 3);
    rx(8'h63);
    idle(8);
    @(negedge clk);
    check("flush_clear_starts", n_sttx - n0, 3);
    check("flush_clear_count", bus.count_o, 1);

    // Line mode fill past capacity with transmitter stuck low.
    do_reset();
    tx_mode = 2;
    for (int i = 0; i < DEP; i++) rx(8'h40 + 8'(i));
    idle(4);
    @(negedge clk);
    check("fill_count", bus.count_o, DEP - 1);
    check("fill_busy", bus.busy_o, 1);
    rx(8'h7A);
    rx(8'h7B);
    idle(2);
    @(negedge clk);
    check("full_count", bus.count_o, DEP);
    check("full_ovf", bus.overflow_o, 1);
    tx_mode = 1;
    wait_drain("fill");

    // Receive in the same cycle as the START pop.
    do_reset();
    bus.mode_i = 1'b0;
    rx(8'hA1);
    rx(8'hA2);
    @(negedge clk);
    check("pop_push_sttx", bus.sttx_o, 1);
    @(negedge clk);
    check("pop_push_count", bus.count_o, 1);
    wait_drain("pop_push");

    // Transmitter never starts: timeout, then next word goes.
    do_reset();
    tx_mode = 0;
    rx(8'h11);
    rx(8'h22);
    wait_sttx("tmo_first", 20);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.timeout_o !== 1'b1 && k < TOC + 10);
    tx_mode = 1;
    check("tmo_delay", k, TOC + 1);
    check("tmo_busy", bus.busy_o, 0);
    @(negedge clk);
    check("tmo_pulse_end", bus.timeout_o, 0);
    check("tmo_next_sttx", bus.sttx_o, 1);
    wait_drain("tmo");

    // Reset during WAIT_BUSY with three words queued.
    do_reset();
    tx_mode = 0;
    for (int i = 0; i < 4; i++) rx(8'h31 + 8'(i));
    idle(2);
    @(negedge clk);
    check("pre_rst_count", bus.count_o, 3);
    do_reset();
    @(negedge clk);
    check("mid_rst_sttx", bus.sttx_o, 0);
    check("mid_rst_txdata", bus.tx_data_o, 0);
    check("mid_rst_count", bus.count_o, 0);
    check("mid_rst_busy", bus.busy_o, 0);
    check("mid_rst_tmo", bus.timeout_o, 0);
    n0 = n_sttx;
    idle(20);
    @(negedge clk);
    check("post_rst_quiet", n_sttx - n0, 0);
    tx_mode = 1;
    rx(8'h55);
    wait_drain("post_rst");
    check("post_rst_one", n_sttx - n0, 1);

    // Random byte-mode traffic.
    do_reset();
    for (int i = 0; i < 80; i++) begin
      rx(8'($urandom));
      idle($urandom_range(0, 4));
    end
    wait_drain("rand_byte");

    // Random line-mode traffic with occasional terminators.
    do_reset();
    bus.mode_i = 1'b1;
    for (int i = 0; i < 80; i++) begin
      w = 8'($urandom);
      if (w == TRM) w = 8'h0E;
      if ($urandom_range(0, 5) == 0) w = TRM;
      rx(w);
      idle($urandom_range(0, 3));
    end
    rx(TRM);
    wait_drain("rand_line");
    check("rand_line_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
